// File: rtl/rsa_pkg.sv
// ============================================================
// Package : rsa_pkg
// Brief   : Shared state encoding and helpers for the modexp engine.
// Rev     : 1.0
// ============================================================
`default_nettype none

package rsa_pkg;

    localparam int DEF_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EVAL = 3'd1,
        MUL  = 3'd2,
        SQR  = 3'd3,
        DONE = 3'd4
    } modexp_state_t;

    // Position of the highest set bit plus one; 0 for a zero operand.
    function automatic int bitlen(input logic [63:0] v);
        int len;
        len = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) len = i + 1;
        end
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_mult_iter.sv
// ============================================================
// Module  : mod_mult_iter
// Brief   : Interleaved MSB-first modular multiplier, one bit per cycle.
// Rev     : 1.0
// ============================================================
`default_nettype none

module mod_mult_iter
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_n_ext;
    logic [WIDTH:0]   w_dbl;
    logic [WIDTH:0]   w_dbl_red;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_add_red;
    logic             w_last;

    // Operands stay below n, so one conditional subtract per step suffices.
    always_comb begin
        w_n_ext   = {1'b0, r_n};
        w_dbl     = {r_r, 1'b0};
        w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
        w_add     = r_a[WIDTH-1] ? (w_dbl_red + {1'b0, r_b}) : w_dbl_red;
        w_add_red = (w_add >= w_n_ext) ? (w_add - w_n_ext) : w_add;
    end

    assign w_last = r_busy && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_n    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_n    <= n;
            r_r    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_r    <= w_add_red[WIDTH-1:0];
            r_a    <= {r_a[WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) r_busy <= 1'b0;
        end
    end

    assign busy = r_busy;
    assign done = w_last;
    assign p    = w_add_red[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/rsa_modexp_ctrl.sv
// ============================================================
// Module  : rsa_modexp_ctrl
// Brief   : Right-to-left square-and-multiply modexp controller.
//           Optional macro MODEXP_CYCLE_CNT_EN adds out_cycles.
// Rev     : 1.0
// ============================================================
`default_nettype none

module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_base,
    input  logic [WIDTH-1:0] in_exp,
    input  logic [WIDTH-1:0] in_mod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err
`ifdef MODEXP_CYCLE_CNT_EN
    ,
    output logic [31:0]      out_cycles
`endif
);

    modexp_state_t    r_state;
    modexp_state_t    w_next_state;

    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_mod;
    logic [WIDTH-1:0] r_acc;
    logic             r_err;

    logic             w_start;
    logic [WIDTH-1:0] w_op_a;
    logic             w_mbusy;
    logic             w_mdone;
    logic [WIDTH-1:0] w_prod;
    logic             w_illegal;

    assign w_illegal = (r_mod < WIDTH'(2)) || (r_base >= r_mod);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // The multiplier is launched on the first cycle of MUL/SQR only (busy low).
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_op_a       = r_acc;
        unique case (r_state)
            IDLE: if (in_valid) w_next_state = EVAL;
            EVAL: begin
                if (w_illegal || (r_exp == '0)) w_next_state = DONE;
                else if (r_exp[0])              w_next_state = MUL;
                else                            w_next_state = SQR;
            end
            MUL: begin
                w_start = !w_mbusy;
                if (w_mdone)
                    w_next_state = (r_exp[WIDTH-1:1] == '0) ? DONE : SQR;
            end
            SQR: begin
                w_op_a  = r_base;
                w_start = !w_mbusy;
                if (w_mdone) w_next_state = EVAL;
            end
            DONE: if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_exp  <= '0;
            r_mod  <= '0;
            r_acc  <= '0;
            r_err  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_base <= in_base;
                        r_exp  <= in_exp;
                        r_mod  <= in_mod;
                        r_acc  <= WIDTH'(1);
                        r_err  <= 1'b0;
                    end
                end
                EVAL: begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                        r_acc <= '0;
                    end else if ((r_exp != '0) && !r_exp[0]) begin
                        r_exp <= r_exp >> 1;
                    end
                end
                MUL: begin
                    if (w_mdone) begin
                        r_acc <= w_prod;
                        r_exp <= r_exp >> 1;
                    end
                end
                SQR: if (w_mdone) r_base <= w_prod;
                default: ;
            endcase
        end
    end

    mod_mult_iter #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .a     (w_op_a),
        .b     (r_base),
        .n     (r_mod),
        .busy  (w_mbusy),
        .done  (w_mdone),
        .p     (w_prod)
    );

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_result = out_valid ? r_acc : '0;
    assign out_err    = out_valid & r_err;

`ifdef MODEXP_CYCLE_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (rst)                                  r_cycles <= '0;
        else if ((r_state == IDLE) && in_valid)   r_cycles <= '0;
        else if ((r_state == EVAL) || (r_state == MUL) || (r_state == SQR))
                                                  r_cycles <= r_cycles + 32'd1;
    end

    assign out_cycles = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
// ============================================================
// Module  : tb_rsa_modexp_ctrl
// Brief   : Scoreboard bench for rsa_modexp_ctrl at WIDTH 16 and 64.
// Rev     : 1.0
// ============================================================
`default_nettype none

module tb_rsa_modexp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v16, ir16, ov16, or16, err16;
    logic [15:0] b16, e16, n16, res16;
    logic        v64, ir64, ov64, or64, err64;
    logic [63:0] b64, e64, n64, res64;
`ifdef MODEXP_CYCLE_CNT_EN
    logic [31:0] cyc16_o, cyc64_o;
`endif

    rsa_modexp_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16),
        .in_base(b16), .in_exp(e16), .in_mod(n16),
        .out_valid(ov16), .out_ready(or16), .out_result(res16), .out_err(err16)
`ifdef MODEXP_CYCLE_CNT_EN
        , .out_cycles(cyc16_o)
`endif
    );

    rsa_modexp_ctrl #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir64),
        .in_base(b64), .in_exp(e64), .in_mod(n64),
        .out_valid(ov64), .out_ready(or64), .out_result(res64), .out_err(err64)
`ifdef MODEXP_CYCLE_CNT_EN
        , .out_cycles(cyc64_o)
`endif
    );

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q64[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Independent left-to-right reference using wide arithmetic.
    function automatic logic [63:0] ref_modexp(input logic [63:0] p, e, n);
        logic [127:0] r;
        logic [127:0] b;
        r = 128'd1;
        b = {64'd0, p} % {64'd0, n};
        for (int i = 63; i >= 0; i--) begin
            r = (r * r) % {64'd0, n};
            if (e[i]) r = (r * b) % {64'd0, n};
        end
        return r[63:0];
    endfunction

    function automatic int ref_lat(input logic [63:0] e, input int w);
        int l;
        l = 1;
        for (int i = 0; i < 64; i++) if (e[i]) l = i + 1;
        return l + ($countones(e) + l - 1) * (w + 1);
    endfunction

    // Expectation is queued on the negedge before the accepting edge.
    task automatic send(input bit w64, input logic [63:0] p, e, n,
                        input logic [63:0] res, input logic err, input int lat);
        exp_t x;
        int   t;
        @(negedge clk);
        if (w64) begin v64 = 1'b1; b64 = p; e64 = e; n64 = n; end
        else     begin v16 = 1'b1; b16 = p[15:0]; e16 = e[15:0]; n16 = n[15:0]; end
        t = 0;
        while (!(w64 ? ir64 : ir16) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!(w64 ? ir64 : ir16)) begin
            timeout(w64 ? "accept64" : "accept16");
            v16 = 1'b0; v64 = 1'b0;
            return;
        end
        x.res = res; x.err = err; x.lat = lat; x.acc = cyc + 1;
        if (w64) q64.push_back(x); else q16.push_back(x);
        @(negedge clk);
        if (w64) begin v64 = 1'b0; b64 = '1; e64 = '1; n64 = 64'd5; end
        else     begin v16 = 1'b0; b16 = '1; e16 = '1; n16 = 16'd5; end
    endtask

    task automatic drain(input bit w64);
        int t;
        t = 0;
        while (((w64 ? q64.size() : q16.size()) != 0 || (w64 ? ov64 : ov16)) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) timeout(w64 ? "drain64" : "drain16");
    endtask

    initial begin : mon16
        exp_t cur;
        logic pv;
        pv = 1'b0;
        cur.res = '0; cur.err = 1'b0; cur.lat = 0; cur.acc = 0;
        forever begin
            @(negedge clk);
            if (ov16 && !pv) begin
                if (q16.size() == 0) begin
                    timeout("unexpected_out16");
                end else begin
                    cur = q16.pop_front();
                    check("lat16", 64'(cyc - cur.acc), 64'(cur.lat));
                    check("res16", {48'd0, res16}, cur.res);
                    check("err16", {63'd0, err16}, {63'd0, cur.err});
                    check("busy_in_ready16", {63'd0, ir16}, 64'd0);
`ifdef MODEXP_CYCLE_CNT_EN
                    check("cycles16", {32'd0, cyc16_o}, 64'(cur.lat));
`endif
                end
            end else if (ov16) begin
                check("hold_res16", {48'd0, res16}, cur.res);
                check("hold_in_ready16", {63'd0, ir16}, 64'd0);
            end
            pv = ov16;
        end
    end

    initial begin : mon64
        exp_t cur;
        logic pv;
        pv = 1'b0;
        cur.res = '0; cur.err = 1'b0; cur.lat = 0; cur.acc = 0;
        forever begin
            @(negedge clk);
            if (ov64 && !pv) begin
                if (q64.size() == 0) begin
                    timeout("unexpected_out64");
                end else begin
                    cur = q64.pop_front();
                    check("lat64", 64'(cyc - cur.acc), 64'(cur.lat));
                    check("res64", res64, cur.res);
                    check("err64", {63'd0, err64}, {63'd0, cur.err});
`ifdef MODEXP_CYCLE_CNT_EN
                    check("cycles64", {32'd0, cyc64_o}, 64'(cur.lat));
`endif
                end
            end else if (ov64) begin
                check("hold_res64", res64, cur.res);
            end
            pv = ov64;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] p, e, n;
        int t;
        rst = 1'b1;
        v16 = 1'b0; b16 = '0; e16 = '0; n16 = '0; or16 = 1'b1;
        v64 = 1'b0; b64 = '0; e64 = '0; n64 = '0; or64 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready16", {63'd0, ir16}, 64'd1);
        check("rst_out_valid16", {63'd0, ov16}, 64'd0);
        check("rst_out_result16", {48'd0, res16}, 64'd0);
        check("rst_out_err16", {63'd0, err16}, 64'd0);
        check("rst_in_ready64", {63'd0, ir64}, 64'd1);
        check("rst_out_valid64", {63'd0, ov64}, 64'd0);

        // Textbook RSA pair, back-to-back, sink stalls 3 cycles on the first result.
        or16 = 1'b0;
        send(1'b0, 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, 107);
        fork
            send(1'b0, 64'd2790, 64'd2753, 64'd3233, 64'd65, 1'b0, 284);
            begin
                t = 0;
                while (!ov16 && t < 1000) begin @(negedge clk); t++; end
                if (!ov16) timeout("stall_wait16");
                repeat (3) @(negedge clk);
                or16 = 1'b1;
            end
        join
        drain(1'b0);

        send(1'b0, 64'd7, 64'd0, 64'd3233, 64'd1, 1'b0, 1);
        send(1'b0, 64'd0, 64'd5, 64'd3233, 64'd0, 1'b0, 71);
        send(1'b0, 64'd0, 64'd5, 64'd1, 64'd0, 1'b1, 1);
        send(1'b0, 64'd3233, 64'd3, 64'd3233, 64'd0, 1'b1, 1);
        drain(1'b0);

        // Abort during the first square; nothing may be emitted.
        send(1'b0, 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, 107);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        q16.delete();
        @(negedge clk);
        check("abort_out_valid16", {63'd0, ov16}, 64'd0);
        check("abort_in_ready16", {63'd0, ir16}, 64'd1);
        rst = 1'b0;
        send(1'b0, 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, 107);
        drain(1'b0);

        send(1'b1, 64'd65, 64'd17, 64'd3233, 64'd2790, 1'b0, 395);
        for (int k = 0; k < 3; k++) begin
            n = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
            p = {$urandom, $urandom} % n;
            e = (k == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
            send(1'b1, p, e, n, ref_modexp(p, e, n), 1'b0, ref_lat(e, 64));
        end
        drain(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
